// File: rtl/dsp_rf_pkg.sv
// Shared constants and types for the 64x32 DSP/GPU register file and its masters.
package dsp_rf_pkg;

    // Register address and data widths; rd64x32d is built from the same values.
    localparam int unsigned RfAw    = 6;
    localparam int unsigned RfDw    = 32;

    // Address bit that selects the upper or lower bank of 32 registers.
    localparam int unsigned BankBit = 5;

    typedef logic [RfAw-1:0] rf_addr_t;
    typedef logic [RfDw-1:0] rf_data_t;

    // Bank of a register address: 0x05 and 0x25 differ only in this bit.
    function automatic logic rf_bank(input rf_addr_t addr);
        return addr[BankBit];
    endfunction

endpackage

// File: rtl/dsp_rf_opfifo.sv
// Two-entry operand-pair FIFO between the RAM read stage and the operand consumer.
// The head entry is presented combinationally; storage resets to zero so the
// outputs read as zero after reset.
module dsp_rf_opfifo
    import dsp_rf_pkg::*;
#(
    parameter int unsigned DW = RfDw,
    parameter int unsigned FD = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_a,
    input  logic [DW-1:0] push_b,
    input  logic          pop,
    output logic [DW-1:0] head_a,
    output logic [DW-1:0] head_b,
    output logic [1:0]    occ
);

    localparam logic [1:0] Full = 2'(FD);

    logic [DW-1:0] mem_a_q [2];
    logic [DW-1:0] mem_b_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    occ_q;
    logic [1:0]    occ_d;
    logic          push_en;
    logic          pop_en;

    // Qualify push/pop so a misbehaving master cannot corrupt the pointers.
    always_comb begin
        pop_en  = pop & (occ_q != 2'd0);
        push_en = push & ((occ_q != Full) | pop_en);
        occ_d   = occ_q;
        unique case ({push_en, pop_en})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_en) begin
                mem_a_q[wr_ptr_q] <= push_a;
                mem_b_q[wr_ptr_q] <= push_b;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop_en) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    // Head of queue drives the consumer side.
    always_comb begin
        head_a = mem_a_q[rd_ptr_q];
        head_b = mem_b_q[rd_ptr_q];
        occ    = occ_q;
    end

    // The issuer's flow control must make a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && !pop && (occ_q == Full)));
        end
    end

endmodule

// File: rtl/dsp_rf_access.sv
// Operand-fetch and writeback sequencer: sole master of both ports of rd64x32d.
// Port A always reads operand A; port B carries either a writeback or the operand B
// read, with writebacks taking absolute priority. Read data returns one cycle after
// the address and is captured into a 2-entry FIFO feeding a valid/ready stream.
module dsp_rf_access
    import dsp_rf_pkg::*;
#(
    parameter int unsigned AW = RfAw,
    parameter int unsigned DW = RfDw,
    parameter int unsigned FD = 2
) (
    input  logic          sys_clk,
    input  logic          resetl,
    // Operand-read issue
    input  logic          iss_valid,
    output logic          iss_ready,
    input  logic [AW-1:0] iss_ra,
    input  logic [AW-1:0] iss_rb,
    // Writeback, never stalled
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_reg,
    input  logic [DW-1:0] wb_data,
    // Operand stream
    output logic          op_valid,
    input  logic          op_ready,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    // RAM port A (read-only)
    output logic [AW-1:0] aa,
    output logic [DW-1:0] da,
    output logic          nwea,
    output logic          clka,
    // RAM port B (shared read/write)
    output logic [AW-1:0] ab,
    output logic [DW-1:0] db,
    output logic          nweb,
    output logic          clkb,
    // RAM read data, valid one cycle after the address
    input  logic [DW-1:0] qa,
    input  logic [DW-1:0] qb
);

    logic       s1_v_q;
    logic [1:0] occ;
    logic       pop;
    logic       accept;
    logic [2:0] level;

    // Flow control: pairs in flight (S1 + FIFO) after this cycle's pop must leave
    // room for one more, and a writeback owns port B so no read can issue with it.
    always_comb begin
        op_valid  = (occ != 2'd0);
        pop       = op_valid & op_ready;
        level     = {1'b0, occ} + {2'b00, s1_v_q} - {2'b00, pop};
        iss_ready = resetl & ~wb_valid & (level < 3'd2);
        accept    = iss_valid & iss_ready;
    end

    // S1 flag: qa/qb carry issued data in the cycle after an accept.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            s1_v_q <= 1'b0;
        end else begin
            s1_v_q <= accept;
        end
    end

    // RAM port mux; write strobes are gated by reset so nothing lands while held.
    always_comb begin
        aa   = iss_ra;
        da   = '0;
        nwea = 1'b1;
        clka = 1'b0;
        ab   = wb_valid ? wb_reg : iss_rb;
        db   = wb_data;
        clkb = wb_valid & resetl;
        nweb = ~(wb_valid & resetl);
    end

    dsp_rf_opfifo #(
        .DW (DW),
        .FD (FD)
    ) u_opfifo (
        .clk    (sys_clk),
        .rst_n  (resetl),
        .push   (s1_v_q),
        .push_a (qa),
        .push_b (qb),
        .pop    (pop),
        .head_a (op_a),
        .head_b (op_b),
        .occ    (occ)
    );

endmodule
